// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response memory bus between a requester (core
// fetch or load/store unit) and a memory responder.
//   master : requester side, drives req_* and rsp_ready_i
//   slave  : responder side, drives req_ready_o and rsp_*
// Signal names carry the responder's point of view (_i into, _o out of it).
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_wen_i;
    logic [ADDR_W-1:0]     req_addr_i;
    logic [DATA_W-1:0]     req_wdata_i;
    logic [DATA_W/8-1:0]   req_mask_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;

    modport slave (
        input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_mask_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_mask_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder backed by an internal
// word array mapped at BASE_ADDR. Each accepted request is answered
// LATENCY+1 cycles after the accepting edge.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous reset, active-high
//   bus    - mem_responder_if.slave (request in, response out)
// DEPTH is assumed to be a power of two (word index taken from address bits).
module mem_responder #(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 64,
    parameter int               DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int               LATENCY   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_responder_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // Range bounds computed one bit wider so BASE_ADDR + size cannot wrap.
    localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(DEPTH * BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    // Captured request; only meaningful between accept and response.
    logic               wen_q, wen_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]   mask_q, mask_d;
    logic               inrange_q, inrange_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               accept;
    logic               enter_resp;
    logic [ADDR_W:0]    addr_ext;

    assign bus.req_ready_o = (state_q == IDLE) & ~rst_i;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    assign accept   = bus.req_valid_i & bus.req_ready_o;
    assign addr_ext = {1'b0, bus.req_addr_i};
    // WAIT always lasts LATENCY+1 cycles (counter runs LATENCY..0), so the
    // response appears after edge T+1+LATENCY even for LATENCY==0.
    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wen_d       = wen_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        inrange_d   = inrange_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wen_d     = bus.req_wen_i;
                    idx_d     = IDX_W'((addr_ext - LO) >> OFF_W);
                    wdata_d   = bus.req_wdata_i;
                    mask_d    = bus.req_mask_i;
                    inrange_d = (addr_ext >= LO) && (addr_ext < HI);
                    cnt_d     = 4'(LATENCY);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = (!wen_q && inrange_q) ? mem_q[idx_q] : '0;
                    err_d       = ~inrange_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Request capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk_i) begin
        wen_q     <= wen_d;
        idx_q     <= idx_d;
        wdata_q   <= wdata_d;
        mask_q    <= mask_d;
        inrange_q <= inrange_d;
    end

    // Array write commits on the edge entering RESP; a reset before that
    // edge abandons it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && wen_q && inrange_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mask_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) share the
// request stimulus; sel picks which one is addressed and observed.
module tb_mem_responder;
    logic clk = 0;
    logic rst = 1;
    logic sel = 0;          // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic        req_valid = 0, req_wen = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0;
    logic [63:0] req_wdata = 0;
    logic [7:0]  req_mask = 0;

    mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus2 ();
    mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus0 ();

    assign bus2.req_valid_i = req_valid & ~sel;
    assign bus0.req_valid_i = req_valid & sel;
    assign bus2.req_wen_i   = req_wen;    assign bus0.req_wen_i   = req_wen;
    assign bus2.req_addr_i  = req_addr;   assign bus0.req_addr_i  = req_addr;
    assign bus2.req_wdata_i = req_wdata;  assign bus0.req_wdata_i = req_wdata;
    assign bus2.req_mask_i  = req_mask;   assign bus0.req_mask_i  = req_mask;
    assign bus2.rsp_ready_i = rsp_ready & ~sel;
    assign bus0.rsp_ready_i = rsp_ready & sel;

    wire        req_ready = sel ? bus0.req_ready_o : bus2.req_ready_o;
    wire        rsp_valid = sel ? bus0.rsp_valid_o : bus2.rsp_valid_o;
    wire [63:0] rsp_rdata = sel ? bus0.rsp_rdata_o : bus2.rsp_rdata_o;
    wire        rsp_err   = sel ? bus0.rsp_err_o   : bus2.rsp_err_o;

    mem_responder #(.LATENCY(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
    mem_responder #(.LATENCY(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] rdata; logic err; } exp_t;
    exp_t sb[$];
    logic [63:0] mdl2 [int];
    logic [63:0] mdl0 [int];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issues one request, predicts its response, checks latency, holds the
    // response for 'hold' cycles of backpressure, then retires it.
    task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [7:0] mask, input int hold);
        exp_t e;
        logic [63:0] old, r0;
        logic e0;
        logic inr;
        int k, t_acc, n;
        int lat;
        lat = sel ? 0 : 2;
        inr = (addr >= 32'h8000_0000) && (addr < 32'h8000_2000);
        k = int'(addr >> 3);
        e.rdata = 64'h0;
        e.err = ~inr;
        if (inr && wen) begin
            old = 64'h0;
            if (sel) begin if (mdl0.exists(k)) old = mdl0[k]; end
            else     begin if (mdl2.exists(k)) old = mdl2[k]; end
            for (int b = 0; b < 8; b++) if (mask[b]) old[b*8 +: 8] = wd[b*8 +: 8];
            if (sel) mdl0[k] = old; else mdl2[k] = old;
        end else if (inr) begin
            if (sel) e.rdata = mdl0.exists(k) ? mdl0[k] : 64'h0;
            else     e.rdata = mdl2.exists(k) ? mdl2[k] : 64'h0;
        end
        @(negedge clk);
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_mask = mask;
        chk({tag, ".ready"}, {63'h0, req_ready}, 64'h1);
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        sb.push_back(e);
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            chk({tag, ".timeout"}, 64'h0, 64'h1);
            void'(sb.pop_front());
            return;
        end
        chk({tag, ".lat"}, 64'(cyc - t_acc), 64'(lat + 1));
        r0 = rsp_rdata; e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".bp_valid"}, {63'h0, rsp_valid}, 64'h1);
            chk({tag, ".bp_rdata"}, rsp_rdata, r0);
            chk({tag, ".bp_err"}, {63'h0, rsp_err}, {63'h0, e0});
            chk({tag, ".bp_ready"}, {63'h0, req_ready}, 64'h0);
        end
        rsp_ready = 1;
        e = sb.pop_front();
        chk({tag, ".rdata"}, rsp_rdata, e.rdata);
        chk({tag, ".err"}, {63'h0, rsp_err}, {63'h0, e.err});
        @(negedge clk);
        rsp_ready = 0;
        chk({tag, ".done_valid"}, {63'h0, rsp_valid}, 64'h0);
        chk({tag, ".idle_ready"}, {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        // Reset: two cycles asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.ready", {63'h0, req_ready}, 64'h0);
            chk("rst.valid", {63'h0, rsp_valid}, 64'h0);
            chk("rst.err",   {63'h0, rsp_err}, 64'h0);
        end
        rst = 0;
        @(negedge clk);
        chk("idle.ready",  {63'h0, req_ready}, 64'h1);
        chk("idle.ready0", {63'h0, bus0.req_ready_o}, 64'h1);
        chk("idle.valid",  {63'h0, rsp_valid}, 64'h0);
        chk("idle.err",    {63'h0, rsp_err}, 64'h0);

        // LATENCY=2 instance
        do_req("wr_full", 1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0);
        do_req("rd_full", 0, 32'h8000_000C, 64'h0, 8'h00, 0);
        do_req("wr_part", 1, 32'h8000_0008, 64'h0000_0000_0000_00AA, 8'h01, 0);
        do_req("rd_part", 0, 32'h8000_0008, 64'h0, 8'h00, 5);
        do_req("wr_w0",   1, 32'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 0);
        do_req("rd_oor",  0, 32'h7FFF_FFF8, 64'h0, 8'h00, 0);
        do_req("wr_oor",  1, 32'h8000_2000, 64'h5555_5555_5555_5555, 8'hFF, 2);
        do_req("rd_w0",   0, 32'h8000_0000, 64'h0, 8'h00, 0);
        do_req("wr_last", 1, 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hF0, 0);
        do_req("rd_last", 0, 32'h8000_1FF8, 64'h0, 8'h00, 0);

        // Reset during WAIT of a write abandons it
        do_req("wr_w2", 1, 32'h8000_0010, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0);
        @(negedge clk);
        req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_mask = 8'hFF;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort.valid", {63'h0, rsp_valid}, 64'h0);
        end
        do_req("rd_w2", 0, 32'h8000_0010, 64'h0, 8'h00, 0);

        // LATENCY=0 instance
        sel = 1;
        do_req("l0_wr", 1, 32'h8000_0100, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 0);
        do_req("l0_rd", 0, 32'h8000_0104, 64'h0, 8'h00, 3);
        do_req("l0_oor", 0, 32'h9000_0000, 64'h0, 8'h00, 0);

        chk("sb.empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
